// File: rtl/fb_mem_arbiter.sv
// rtl/fb_mem_arbiter.sv - frame-buffer memory port arbiter for display read / camera write bursts
//
// Purpose: picks one requester per burst, drives the memory command handshake,
// counts data beats and pulses grant/done per direction.
// Optional feature macro: ARB_STARVE_GUARD_EN (forces a pending write after
// MAX_RD_WINS consecutive read wins, even over an urgent read).
//
// Ports:
//   i_clk, i_rstn                      clock, asynchronous active-low reset
//   i_rd_req/i_rd_addr/i_rd_urgent     display read burst request
//   o_rd_gnt, o_rd_done                read command accepted / last read beat pulses
//   i_wr_req/i_wr_addr                 camera write burst request
//   o_wr_gnt, o_wr_done                write command accepted / last write beat pulses
//   o_mem_cmd_valid/_we/_addr          command to memory controller
//   i_mem_cmd_ready                    memory accepts command
//   i_mem_beat                         one data beat transferred this cycle
//   o_busy                             high while in CMD or XFER

module fb_mem_arbiter #(
   parameter int ADDR_W      = 19,
   parameter int BURST_LEN   = 16,
   parameter int MAX_RD_WINS = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   input  logic              i_rd_urgent,
   output logic              o_rd_gnt,
   output logic              o_rd_done,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   output logic              o_wr_gnt,
   output logic              o_wr_done,
   output logic              o_mem_cmd_valid,
   output logic              o_mem_cmd_we,
   output logic [ADDR_W-1:0] o_mem_cmd_addr,
   input  logic              i_mem_cmd_ready,
   input  logic              i_mem_beat,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] L_LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_beat_cnt;
   logic             r_last_wr;   // 1: last served burst was a write
   logic             w_pick_wr;

`ifdef ARB_STARVE_GUARD_EN
   localparam int WIN_W = $clog2(MAX_RD_WINS + 1);
   localparam logic [WIN_W-1:0] L_MAX_WINS = WIN_W'(MAX_RD_WINS);
   logic [WIN_W-1:0] r_rd_wins;
`endif

   // Decision for the current IDLE cycle; only consumed when a request is pending.
   always_comb begin
      w_pick_wr = 1'b0;
      if (i_rd_req && i_rd_urgent)
         w_pick_wr = 1'b0;
      else if (i_rd_req && i_wr_req)
         w_pick_wr = ~r_last_wr;
      else
         w_pick_wr = i_wr_req;
`ifdef ARB_STARVE_GUARD_EN
      // Starvation guard overrides even an urgent read.
      if (i_wr_req && (r_rd_wins == L_MAX_WINS))
         w_pick_wr = 1'b1;
`endif
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state         <= S_IDLE;
         r_beat_cnt      <= '0;
         r_last_wr       <= 1'b1;
         o_rd_gnt        <= 1'b0;
         o_rd_done       <= 1'b0;
         o_wr_gnt        <= 1'b0;
         o_wr_done       <= 1'b0;
         o_mem_cmd_valid <= 1'b0;
         o_mem_cmd_we    <= 1'b0;
         o_mem_cmd_addr  <= '0;
         o_busy          <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
         r_rd_wins       <= '0;
`endif
      end else begin
         o_rd_gnt  <= 1'b0;
         o_wr_gnt  <= 1'b0;
         o_rd_done <= 1'b0;
         o_wr_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_rd_req || i_wr_req) begin
                  r_state         <= S_CMD;
                  o_mem_cmd_valid <= 1'b1;
                  o_busy          <= 1'b1;
                  o_mem_cmd_we    <= w_pick_wr;
                  o_mem_cmd_addr  <= w_pick_wr ? i_wr_addr : i_rd_addr;
`ifdef ARB_STARVE_GUARD_EN
                  if (!i_wr_req)
                     r_rd_wins <= '0;
                  else if (!w_pick_wr && (r_rd_wins != L_MAX_WINS))
                     r_rd_wins <= r_rd_wins + 1'b1;
`endif
               end
            end
            S_CMD: begin
               if (i_mem_cmd_ready) begin
                  r_state         <= S_XFER;
                  r_beat_cnt      <= '0;
                  o_mem_cmd_valid <= 1'b0;
                  r_last_wr       <= o_mem_cmd_we;
                  o_rd_gnt        <= ~o_mem_cmd_we;
                  o_wr_gnt        <= o_mem_cmd_we;
`ifdef ARB_STARVE_GUARD_EN
                  if (o_mem_cmd_we)
                     r_rd_wins <= '0;
`endif
               end
            end
            S_XFER: begin
               if (i_mem_beat) begin
                  if (r_beat_cnt == L_LAST_BEAT) begin
                     r_state    <= S_IDLE;
                     r_beat_cnt <= '0;
                     o_busy     <= 1'b0;
                     o_rd_done  <= ~o_mem_cmd_we;
                     o_wr_done  <= o_mem_cmd_we;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb/tb_fb_mem_arbiter.sv - self-checking bench for fb_mem_arbiter

module tb_fb_mem_arbiter;

   localparam int AW = 19;
   localparam int BL = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_req, rd_urgent, wr_req, cmd_ready, mem_beat;
   logic [AW-1:0] rd_addr, wr_addr;
   logic          rd_gnt, rd_done, wr_gnt, wr_done;
   logic          cmd_valid, cmd_we, busy;
   logic [AW-1:0] cmd_addr;

   int checks = 0;
   int errors = 0;

   logic [AW:0] sb[$];

   typedef struct {
      bit          rd;
      bit          wr;
      bit          urg;
      logic [AW-1:0] ra;
      logic [AW-1:0] wa;
      bit          exp_we;
      int          rdly;
      bit          acc_beat;
   } vec_t;

   vec_t tbl[13];

   always #5 clk = ~clk;

   fb_mem_arbiter #(.ADDR_W(AW), .BURST_LEN(BL), .MAX_RD_WINS(4)) dut (
      .i_clk(clk), .i_rstn(rst_n),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .i_rd_urgent(rd_urgent),
      .o_rd_gnt(rd_gnt), .o_rd_done(rd_done),
      .i_wr_req(wr_req), .i_wr_addr(wr_addr),
      .o_wr_gnt(wr_gnt), .o_wr_done(wr_done),
      .o_mem_cmd_valid(cmd_valid), .o_mem_cmd_we(cmd_we), .o_mem_cmd_addr(cmd_addr),
      .i_mem_cmd_ready(cmd_ready), .i_mem_beat(mem_beat), .o_busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, cmd_valid, 0);
      chk({tag, "_we"},    cmd_we, 0);
      chk({tag, "_addr"},  cmd_addr, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_pulses"}, {rd_gnt, wr_gnt, rd_done, wr_done}, 0);
   endtask

   task automatic run_burst(input vec_t v);
      logic [AW:0] exp;
      rd_req = v.rd; wr_req = v.wr; rd_urgent = v.urg;
      rd_addr = v.ra; wr_addr = v.wa;
      sb.push_back({v.exp_we, v.exp_we ? v.wa : v.ra});
      @(negedge clk);
      chk("cmd_valid_latency", cmd_valid, 1);
      exp = sb.pop_front();
      chk("cmd_we", cmd_we, exp[AW]);
      chk("cmd_addr", cmd_addr, exp[AW-1:0]);
      for (int i = 0; i < v.rdly; i++) begin
         @(negedge clk);
         chk("stall_valid", cmd_valid, 1);
         chk("stall_we", cmd_we, exp[AW]);
         chk("stall_addr", cmd_addr, exp[AW-1:0]);
         chk("stall_no_gnt", {rd_gnt, wr_gnt}, 0);
      end
      cmd_ready = 1'b1;
      mem_beat = v.acc_beat;
      @(negedge clk);
      cmd_ready = 1'b0; mem_beat = 1'b0;
      rd_req = 1'b0; wr_req = 1'b0; rd_urgent = 1'b0;
      chk("gnt_dir", {rd_gnt, wr_gnt}, {~exp[AW], exp[AW]});
      chk("valid_drop", cmd_valid, 0);
      for (int b = 0; b < BL; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            chk("gap_no_done", {rd_done, wr_done}, 0);
         end
         mem_beat = 1'b1;
         @(negedge clk);
         mem_beat = 1'b0;
         if (b == BL - 1)
            chk("done_dir", {rd_done, wr_done}, {~exp[AW], exp[AW]});
         else
            chk("early_done", {rd_done, wr_done}, 0);
      end
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      tbl[0]  = '{1, 0, 0, 19'h00100, 19'h00000, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 19'h00000, 19'h02000, 1, 0, 0};
      tbl[2]  = '{1, 1, 0, 19'h00110, 19'h02010, 0, 0, 1};
      tbl[3]  = '{1, 1, 0, 19'h00120, 19'h02020, 1, 0, 0};
      tbl[4]  = '{1, 1, 0, 19'h00130, 19'h02030, 0, 0, 0};
      tbl[5]  = '{1, 1, 0, 19'h00140, 19'h02040, 1, 0, 1};
      tbl[6]  = '{0, 1, 0, 19'h00000, 19'h7FFFF, 1, 10, 0};
      for (int i = 0; i < 6; i++)
         tbl[7+i] = '{1, 1, 1, 19'h00200 + 19'(i * 16), 19'h03000, 0, 0, 0};
`ifdef ARB_STARVE_GUARD_EN
      tbl[11].exp_we = 1;
`endif

      rst_n = 1'b0;
      rd_req = 0; wr_req = 0; rd_urgent = 0; cmd_ready = 0; mem_beat = 0;
      rd_addr = '0; wr_addr = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Beats with nothing in flight must be ignored.
      for (int i = 0; i < 4; i++) begin
         mem_beat = 1'b1;
         @(negedge clk);
         chk("idle_beat_busy", busy, 0);
         chk("idle_beat_done", {rd_done, wr_done}, 0);
      end
      mem_beat = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) run_burst(tbl[i]);

      // Asynchronous reset at beat 7 of a read burst.
      rd_req = 1'b1; rd_addr = 19'h00300;
      @(negedge clk);
      chk("rst_seq_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0; rd_req = 1'b0;
      chk("rst_seq_gnt", rd_gnt, 1);
      for (int b = 0; b < 7; b++) begin
         mem_beat = 1'b1;
         @(negedge clk);
      end
      mem_beat = 1'b0;
      chk("rst_seq_busy_pre", busy, 1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_done", {rd_done, wr_done}, 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      run_burst('{1, 1, 0, 19'h00400, 19'h04000, 0, 0, 0});
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
